// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================================
// pwm_pkg : constants and state type shared by the 4-bit PWM generator/decoder
// Revision: 1.0
// ============================================================================
package pwm_pkg;

  localparam int PWM_PERIOD  = 16;
  localparam int PWM_VALUE_W = 4;

  typedef enum logic [1:0] {
    ACQ  = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } pwm_dec_state_t;

endpackage
`default_nettype wire

// File: rtl/pwm_duty_decoder_if.sv
`default_nettype none
// ============================================================================
// pwm_duty_decoder_if : PWM line in, recovered duty value/status out
// Revision: 1.0
// ============================================================================
interface pwm_duty_decoder_if
  import pwm_pkg::*;
#(
  parameter int VALUE_W = PWM_VALUE_W
);

  logic               pwm_in;
  logic [VALUE_W-1:0] value;
  logic               valid;
  logic               period_err;
  logic               locked;

  modport master (output pwm_in, input value, valid, period_err, locked);
  modport slave  (input pwm_in, output value, valid, period_err, locked);

endinterface
`default_nettype wire

// File: rtl/pwm_in_sync.sv
`default_nettype none
// ============================================================================
// pwm_in_sync : synchronizer chain for the async PWM line plus edge detection
// Revision: 1.0
// ============================================================================
module pwm_in_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic pwm_in,
  output logic s,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_s_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
      r_s_d  <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], pwm_in};
      r_s_d  <= r_sync[SYNC_STAGES-1];
    end
  end

  assign s    = r_sync[SYNC_STAGES-1];
  assign rise = s & ~r_s_d;
  assign fall = ~s & r_s_d;

endmodule
`default_nettype wire

// File: rtl/pwm_duty_decoder.sv
`default_nettype none
// ============================================================================
// pwm_duty_decoder : measures high time and period of a PWM line and publishes
//                    the duty value with a one-cycle valid strobe
// Revision: 1.0
// ============================================================================
module pwm_duty_decoder
  import pwm_pkg::*;
#(
  parameter int VALUE_W     = PWM_VALUE_W,
  parameter int PERIOD      = PWM_PERIOD,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 48
) (
  input  logic               clk,
  input  logic               rst,
  pwm_duty_decoder_if.slave  bus
);

  localparam int                 CNT_W     = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]   CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]   IDLE_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [VALUE_W-1:0] VAL_MAX   = '1;

  logic                 w_s, w_rise, w_fall;
  pwm_dec_state_t       r_state, w_state_nxt;
  logic [CNT_W-1:0]     r_hi_cnt, r_per_cnt, r_idle_cnt;
  logic [CNT_W-1:0]     w_hi_nxt, w_per_nxt, w_idle_nxt;
  logic                 w_timeout, w_pub_rise;
  logic [VALUE_W-1:0]   w_hi_clip;
  logic [VALUE_W-1:0]   r_value;
  logic                 r_valid, r_period_err, r_locked;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
    return (x == CNT_MAX) ? x : x + CNT_ONE;
  endfunction

  pwm_in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk    (clk),
    .rst    (rst),
    .pwm_in (bus.pwm_in),
    .s      (w_s),
    .rise   (w_rise),
    .fall   (w_fall)
  );

  // Any edge restarts the idle window, so a rise coinciding with expiry wins.
  assign w_timeout = !w_rise && !w_fall && (r_idle_cnt == IDLE_LAST);
  assign w_hi_clip = (r_hi_cnt > CNT_W'(VAL_MAX)) ? VAL_MAX : r_hi_cnt[VALUE_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ACQ;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_timeout) begin
      w_state_nxt = ACQ;
    end else begin
      case (r_state)
        ACQ:     if (w_rise) w_state_nxt = HIGH;
        HIGH:    if (w_fall) w_state_nxt = LOW;
        LOW:     if (w_rise) w_state_nxt = HIGH;
        default: w_state_nxt = ACQ;
      endcase
    end
  end

  always_comb begin
    w_hi_nxt   = r_hi_cnt;
    w_per_nxt  = r_per_cnt;
    w_pub_rise = 1'b0;
    w_idle_nxt = (w_rise || w_fall || w_timeout) ? '0 : sat_inc(r_idle_cnt);
    case (r_state)
      ACQ: begin
        w_hi_nxt  = w_rise ? CNT_ONE : '0;
        w_per_nxt = w_rise ? CNT_ONE : '0;
      end
      HIGH: begin
        w_per_nxt = sat_inc(r_per_cnt);
        if (w_s) w_hi_nxt = sat_inc(r_hi_cnt);
      end
      LOW: begin
        if (w_rise) begin
          w_pub_rise = 1'b1;
          w_hi_nxt   = CNT_ONE;
          w_per_nxt  = CNT_ONE;
        end else begin
          w_per_nxt  = sat_inc(r_per_cnt);
        end
      end
      default: begin
        w_hi_nxt  = '0;
        w_per_nxt = '0;
      end
    endcase
    if (w_timeout) begin
      w_hi_nxt  = '0;
      w_per_nxt = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hi_cnt     <= '0;
      r_per_cnt    <= '0;
      r_idle_cnt   <= '0;
      r_value      <= '0;
      r_valid      <= 1'b0;
      r_period_err <= 1'b0;
      r_locked     <= 1'b0;
    end else begin
      r_hi_cnt   <= w_hi_nxt;
      r_per_cnt  <= w_per_nxt;
      r_idle_cnt <= w_idle_nxt;
      r_valid    <= w_pub_rise | w_timeout;
      r_locked   <= (r_state != ACQ);
      if (w_pub_rise) begin
        r_value      <= w_hi_clip;
        r_period_err <= (r_per_cnt != CNT_W'(PERIOD));
      end else if (w_timeout) begin
        r_value      <= w_s ? VAL_MAX : '0;
        r_period_err <= 1'b0;
      end
    end
  end

  assign bus.value      = r_value;
  assign bus.valid      = r_valid;
  assign bus.period_err = r_period_err;
  assign bus.locked     = r_locked;

endmodule
`default_nettype wire
